// File: rtl/accum_dump_reader.sv
// Reader side of the FFT accumulation path: windows N samples, dumps and clears the accumulator,
// scales to a rounded/saturated average and buffers it in a 2-entry FIFO. Macro ACC_DUMP_ROUND_EN selects round half-up.
module accum_dump_reader #(
    parameter int ACC_W  = 20,
    parameter int LOG2_N = 4,
    parameter int OUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 ce,
    input  logic [2*ACC_W-1:0]   acc_in,
    output logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*OUT_W-1:0]   out_data,
    output logic                 overflow
);

    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

`ifdef ACC_DUMP_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(2 ** (LOG2_N - 1));
`else
    localparam logic signed [ACC_W:0] RND = '0;
`endif

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [LOG2_N-1:0]  cnt_q, cnt_d;
    logic               cap_pend_q, cap_pend_d;
    logic [2*OUT_W-1:0] scaled;

    logic [2*OUT_W-1:0] mem_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;
    logic               overflow_q, overflow_d;
    logic               wr, wr_acc, pop;

    always_comb begin
        cnt_d      = ce ? cnt_q + LOG2_N'(1) : cnt_q;
        cap_pend_d = ce && (cnt_q == CNT_LAST);
    end

    // The capture cycle scales acc_in combinationally; the FIFO entry is the registered stage.
    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] shr;
        logic [OUT_W-1:0]      sat;

        assign ext = $signed({acc_in[gi*ACC_W+ACC_W-1], acc_in[gi*ACC_W +: ACC_W]}) + RND;
        assign shr = ext >>> LOG2_N;

        always_comb begin
            if (shr > SAT_MAX) begin
                sat = SAT_MAX[OUT_W-1:0];
            end else if (shr < SAT_MIN) begin
                sat = SAT_MIN[OUT_W-1:0];
            end else begin
                sat = shr[OUT_W-1:0];
            end
        end

        assign scaled[gi*OUT_W +: OUT_W] = sat;
    end

    assign wr     = cap_pend_q;
    assign pop    = out_valid && out_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign wr_acc = wr && ((occ_q != FULL) || pop);

    always_comb begin
        occ_d      = occ_q;
        wr_ptr_d   = wr_acc ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
        overflow_d = overflow_q || (wr && !wr_acc);
        case (occ_q)
            EMPTY: if (wr) occ_d = ONE;
            ONE: begin
                if (wr && !pop) begin
                    occ_d = FULL;
                end else if (!wr && pop) begin
                    occ_d = EMPTY;
                end
            end
            FULL: if (pop && !wr) occ_d = ONE;
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q      <= '0;
            cap_pend_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= EMPTY;
            overflow_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            cap_pend_q <= cap_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            if (wr_acc) begin
                mem_q[wr_ptr_q] <= scaled;
            end
        end
    end

    assign acc_clr   = cap_pend_q;
    assign out_valid = (occ_q != EMPTY);
    assign out_data  = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_accum_dump_reader.sv
// Scoreboard bench for accum_dump_reader: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_accum_dump_reader;

    localparam int ACC_W  = 20;
    localparam int LOG2_N = 4;
    localparam int OUT_W  = 16;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic                 ce;
    logic [2*ACC_W-1:0]   acc_in;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*OUT_W-1:0]   out_data;
    logic                 overflow;

    always #5 clk = ~clk;

    accum_dump_reader #(
        .ACC_W  (ACC_W),
        .LOG2_N (LOG2_N),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ce        (ce),
        .acc_in    (acc_in),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    // Accumulator model: adds samples, clear-loads while acc_clr is high.
    logic signed [ACC_W-1:0] acc_re, acc_im, samp_re, samp_im, frc_re, frc_im;
    logic                    force_en;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (acc_clr) begin
            acc_re <= ce ? samp_re : '0;
            acc_im <= ce ? samp_im : '0;
        end else if (ce) begin
            acc_re <= acc_re + samp_re;
            acc_im <= acc_im + samp_im;
        end
    end

    assign acc_in = force_en ? {frc_re, frc_im} : {acc_re, acc_im};

    int n_checks  = 0;
    int n_fail    = 0;
    int clr_count = 0;
    int n_words   = 0;
    int base;
    logic [2*OUT_W-1:0] exp_q [$];
    logic [2*OUT_W-1:0] mon_exp;

    function automatic logic [2*OUT_W-1:0] word(input int re, input int im);
        word = {OUT_W'(re), OUT_W'(im)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    task automatic cyc(input logic c, input int re, input int im);
        ce      = c;
        samp_re = ACC_W'(re);
        samp_im = ACC_W'(im);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (acc_clr) clr_count++;
        if (nrst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got re=%0d im=%0d, required no word",
                         $signed(out_data[2*OUT_W-1:OUT_W]), $signed(out_data[OUT_W-1:0]));
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL word%0d: got re=%0d im=%0d, required re=%0d im=%0d", n_words,
                             $signed(out_data[2*OUT_W-1:OUT_W]), $signed(out_data[OUT_W-1:0]),
                             $signed(mon_exp[2*OUT_W-1:OUT_W]), $signed(mon_exp[OUT_W-1:0]));
                end else begin
                    $display("word%0d: re=%0d im=%0d ok", n_words,
                             $signed(out_data[2*OUT_W-1:OUT_W]), $signed(out_data[OUT_W-1:0]));
                end
                n_words++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst      = 1'b0;
        ce        = 1'b0;
        out_ready = 1'b1;
        force_en  = 1'b0;
        samp_re   = '0;
        samp_im   = '0;
        frc_re    = '0;
        frc_im    = '0;

        // Reset held with ce toggling
        for (int i = 0; i < 6; i++) cyc(logic'(i % 2), 0, 0);
        @(negedge clk);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        ce = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // 16 ce pulses with gaps -> one acc_clr right after the 16th
        base = clr_count;
        exp_q.push_back(word(0, 0));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 0, 0);
            if (i != 15) cyc(1'b0, 0, 0);
        end
        ce = 1'b0;
        chk("clr_after_16th", acc_clr, 1);
        repeat (4) cyc(1'b0, 0, 0);
        chk("clr_pulse_count", clr_count - base, 1);

        // Constant input, back-to-back windows
        for (int w = 0; w < 4; w++) exp_q.push_back(word(100, -50));
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 100, -50);
            chk($sformatf("clr_phase%0d", i), acc_clr, (i % 16) == 15);
        end
        repeat (4) cyc(1'b0, 0, 0);
        chk("const_overflow", overflow, 0);
        chk("const_drained", exp_q.size(), 0);

        // Rounding
`ifdef ACC_DUMP_ROUND_EN
        exp_q.push_back(word(2, -1));
`else
        exp_q.push_back(word(1, -2));
`endif
        for (int i = 0; i < 16; i++) cyc(1'b1, (i == 0) ? 24 : 0, (i == 0) ? -24 : 0);
        repeat (4) cyc(1'b0, 0, 0);
        chk("round_drained", exp_q.size(), 0);

        // Saturation at the extremes of the accumulator range
        force_en = 1'b1;
        frc_re   = ACC_W'(524287);
        frc_im   = ACC_W'(-524288);
        exp_q.push_back(word(32767, -32768));
        for (int i = 0; i < 16; i++) cyc(1'b1, 0, 0);
        repeat (4) cyc(1'b0, 0, 0);
        force_en = 1'b0;
        chk("sat_drained", exp_q.size(), 0);

        // Full FIFO, pop exactly on the write cycle
        out_ready = 1'b0;
        for (int w = 0; w < 3; w++) exp_q.push_back(word(200 + w, -(7 + w)));
        for (int i = 0; i < 48; i++) cyc(1'b1, 200 + i / 16, -(7 + i / 16));
        chk("third_capture", acc_clr, 1);
        chk("full_valid", out_valid, 1);
        ce        = 1'b0;
        out_ready = 1'b1;
        cyc(1'b0, 0, 0);
        out_ready = 1'b0;
        chk("simul_overflow", overflow, 0);
        repeat (2) cyc(1'b0, 0, 0);
        out_ready = 1'b1;
        cyc(1'b0, 0, 0);
        chk("simul_one_left", out_valid, 1);
        cyc(1'b0, 0, 0);
        chk("simul_empty", out_valid, 0);
        chk("simul_drained", exp_q.size(), 0);
        chk("simul_overflow_end", overflow, 0);

        // Backpressure over three windows: third dropped
        out_ready = 1'b0;
        exp_q.push_back(word(10, -3));
        exp_q.push_back(word(20, -6));
        for (int i = 0; i < 48; i++) cyc(1'b1, 10 * (i / 16 + 1), -3 * (i / 16 + 1));
        ce = 1'b0;
        repeat (3) cyc(1'b0, 0, 0);
        chk("bp_overflow", overflow, 1);
        chk("bp_valid", out_valid, 1);
        chk("bp_head_stable", out_data, exp_q[0]);
        out_ready = 1'b1;
        repeat (4) cyc(1'b0, 0, 0);
        chk("bp_overflow_sticky", overflow, 1);
        chk("bp_empty", out_valid, 0);
        chk("bp_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
